// File: rtl/lfsr_gen.sv
// Fibonacci LFSR: shifts left every clock, XOR of the tapped state bits enters bit 0.
// Power-up and reset load SEED; an all-zero state is forced to 1 so the register can never lock up.
module lfsr_gen #(
    parameter int                  NUM_BITS = 5,
    parameter logic [NUM_BITS-1:0] SEED     = NUM_BITS'(1),
    parameter logic [NUM_BITS-1:0] TAPS     = NUM_BITS'(5'h12)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    output logic                o_randomBit,
    output logic [NUM_BITS-1:0] o_state
);

    localparam logic [NUM_BITS-1:0] ONE         = NUM_BITS'(1);
    localparam logic [NUM_BITS-1:0] RESET_VALUE = (SEED == '0) ? ONE : SEED;

    if (NUM_BITS < 2 || NUM_BITS > 32) begin : g_bad_width
        $error("lfsr_gen: NUM_BITS must be in the range 2..32");
    end

    if (TAPS[NUM_BITS-1] == 1'b0) begin : g_bad_taps
        $error("lfsr_gen: TAPS must include the most significant state bit");
    end

    // The declaration initialiser gives a valid state even if i_rst is never driven.
    logic [NUM_BITS-1:0] state = RESET_VALUE;
    logic [NUM_BITS-1:0] next_state;
    logic                fb;

    always_comb begin
        fb         = ^(state & TAPS);
        next_state = {state[NUM_BITS-2:0], fb};
        if (state == '0) begin
            next_state = ONE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= RESET_VALUE;
        end else begin
            state <= next_state;
        end
    end

    assign o_state     = state;
    assign o_randomBit = state[NUM_BITS-1];

endmodule

// File: tb/tb_lfsr_gen.sv
// Bench for lfsr_gen: seven instances on one clock, compared every cycle against an arithmetic LFSR model.
module tb_lfsr_gen;

    localparam int NUM_INST = 7;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic [NUM_INST-1:0] rst = '0;
    logic [NUM_INST-1:0] rb;
    logic [4:0] st_a, st_b, st_c, st_d;
    logic [7:0] st_e, st_f, st_g;
    logic [31:0] actual_state [NUM_INST];

    lfsr_gen #(.NUM_BITS(5), .SEED(5'h01), .TAPS(5'h12)) dut (
        .i_clk(clk), .i_rst(rst[0]), .o_randomBit(rb[0]), .o_state(st_a));
    lfsr_gen #(.NUM_BITS(5), .SEED(5'h01), .TAPS(5'h1B)) u_taps_1b (
        .i_clk(clk), .i_rst(rst[1]), .o_randomBit(rb[1]), .o_state(st_b));
    lfsr_gen #(.NUM_BITS(5), .SEED(5'h01), .TAPS(5'h1E)) u_taps_1e (
        .i_clk(clk), .i_rst(rst[2]), .o_randomBit(rb[2]), .o_state(st_c));
    lfsr_gen #(.NUM_BITS(5), .SEED(5'h00), .TAPS(5'h12)) u_seed0 (
        .i_clk(clk), .i_rst(rst[3]), .o_randomBit(rb[3]), .o_state(st_d));
    lfsr_gen #(.NUM_BITS(8), .SEED(8'h01), .TAPS(8'hB8)) u_w8_a (
        .i_clk(clk), .i_rst(rst[4]), .o_randomBit(rb[4]), .o_state(st_e));
    lfsr_gen #(.NUM_BITS(8), .SEED(8'h5A), .TAPS(8'hB8)) u_w8_b (
        .i_clk(clk), .i_rst(rst[5]), .o_randomBit(rb[5]), .o_state(st_f));
    lfsr_gen #(.NUM_BITS(8), .SEED(8'hC3), .TAPS(8'hB8)) u_w8_c (
        .i_clk(clk), .i_rst(rst[6]), .o_randomBit(rb[6]), .o_state(st_g));

    assign actual_state[0] = {27'b0, st_a};
    assign actual_state[1] = {27'b0, st_b};
    assign actual_state[2] = {27'b0, st_c};
    assign actual_state[3] = {27'b0, st_d};
    assign actual_state[4] = {24'b0, st_e};
    assign actual_state[5] = {24'b0, st_f};
    assign actual_state[6] = {24'b0, st_g};

    int n_bits [NUM_INST] = '{5, 5, 5, 5, 8, 8, 8};
    int taps   [NUM_INST] = '{'h12, 'h1B, 'h1E, 'h12, 'hB8, 'hB8, 'hB8};
    int seeds  [NUM_INST] = '{'h01, 'h01, 'h01, 'h00, 'h01, 'h5A, 'hC3};
    int model  [NUM_INST];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic [4:0] state;
        logic       rbit;
    } vec_t;

    vec_t tbl [15];

    // Reference: multiply by two modulo 2^n, then add the parity of the tapped bits.
    function automatic int model_next(int s, int n, int t);
        if (s == 0) return 1;
        return ((s * 2) % (1 << n)) + ($countones(s & t) % 2);
    endfunction

    function automatic int reset_value(int i);
        return (seeds[i] == 0) ? 1 : seeds[i];
    endfunction

    task automatic check_output(string name, int actual, int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NUM_INST; i++) begin
            check_output($sformatf("inst%0d state", i), int'(actual_state[i]), model[i]);
            check_output($sformatf("inst%0d random bit", i), int'(rb[i]),
                         (model[i] >> (n_bits[i] - 1)) & 1);
        end
    endtask

    // Drive the reset vector, take one clock edge, advance the model and compare everything.
    task automatic apply_stimulus(input logic [NUM_INST-1:0] r);
        rst = r;
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_INST; i++) begin
            model[i] = r[i] ? reset_value(i) : model_next(model[i], n_bits[i], taps[i]);
        end
        check_all();
    endtask

    initial begin
        bit seen [NUM_INST][256];
        int distinct [NUM_INST];
        int ones;

        tbl[0]  = '{1'b1, 5'h01, 1'b0};
        tbl[1]  = '{1'b0, 5'h02, 1'b0};
        tbl[2]  = '{1'b0, 5'h05, 1'b0};
        tbl[3]  = '{1'b0, 5'h0A, 1'b0};
        tbl[4]  = '{1'b0, 5'h15, 1'b1};
        tbl[5]  = '{1'b0, 5'h0B, 1'b0};
        tbl[6]  = '{1'b0, 5'h17, 1'b1};
        tbl[7]  = '{1'b0, 5'h0E, 1'b0};
        tbl[8]  = '{1'b1, 5'h01, 1'b0};
        tbl[9]  = '{1'b1, 5'h01, 1'b0};
        tbl[10] = '{1'b1, 5'h01, 1'b0};
        tbl[11] = '{1'b0, 5'h02, 1'b0};
        tbl[12] = '{1'b0, 5'h05, 1'b0};
        tbl[13] = '{1'b0, 5'h0A, 1'b0};
        tbl[14] = '{1'b0, 5'h15, 1'b1};

        // Power-up without any reset: every instance must start from its seed (or 1 for seed 0).
        #1;
        ones = 0;
        for (int i = 0; i < NUM_INST; i++) begin
            model[i]    = reset_value(i);
            distinct[i] = 0;
            for (int k = 0; k < 256; k++) seen[i][k] = 1'b0;
        end
        check_output("power-up dut state", int'(st_a), 'h01);
        check_output("power-up seed0 state", int'(st_d), 'h01);
        check_all();

        // Full-period sweep: distinct states, return to start, and the ones count for the default taps.
        for (int c = 0; c <= 255; c++) begin
            if (c > 0) apply_stimulus('0);
            for (int i = 0; i < NUM_INST; i++) begin
                int period;
                period = (1 << n_bits[i]) - 1;
                if (c < period) begin
                    if (!seen[i][actual_state[i][7:0]] && actual_state[i] != 0) distinct[i]++;
                    seen[i][actual_state[i][7:0]] = 1'b1;
                end
                if (c == period) begin
                    check_output($sformatf("inst%0d period return", i),
                                 int'(actual_state[i]), reset_value(i));
                end
            end
            if (c < 31 && rb[0]) ones++;
        end
        for (int i = 0; i < NUM_INST; i++) begin
            check_output($sformatf("inst%0d distinct states", i), distinct[i], (1 << n_bits[i]) - 1);
        end
        check_output("ones per period", ones, 16);

        // Reset mid-run on the default instance, against hand-computed reference values.
        for (int k = 0; k < 15; k++) begin
            apply_stimulus({6'b0, tbl[k].rst});
            check_output($sformatf("table[%0d] state", k), int'(st_a), int'(tbl[k].state));
            check_output($sformatf("table[%0d] random bit", k), int'(rb[0]), int'(tbl[k].rbit));
        end

        // Zero seed after an explicit reset.
        apply_stimulus(7'b0001000);
        check_output("seed0 after reset", int'(st_d), 'h01);
        apply_stimulus('0);
        check_output("seed0 step 1", int'(st_d), 'h02);
        apply_stimulus('0);
        check_output("seed0 step 2", int'(st_d), 'h05);

        // Randomised independent resets across all instances.
        for (int c = 0; c < 400; c++) begin
            logic [NUM_INST-1:0] r;
            for (int i = 0; i < NUM_INST; i++) r[i] = ($urandom_range(0, 11) == 0);
            apply_stimulus(r);
        end

        rst = '0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
